// File: rtl/pc_sequencer.sv
// Y86-64 front-end PC sequencer: owns predicted PC, selects fetch address, sequences ret/halt.
// Zero-cycle redirect on mispredict/ret; state and pred_pc update on the next rising edge.
module pc_sequencer #(
    parameter logic [63:0] RESET_PC    = 64'h0,
    parameter logic [3:0]  RET_TIMEOUT = 4'd15
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [3:0]  icode_i,
    input  logic [63:0] valC_i,
    input  logic [63:0] valP_i,
    input  logic        instr_valid_i,
    input  logic        imem_error_i,
    input  logic        stall_i,
    input  logic        mispredict_i,
    input  logic [63:0] M_valA_i,
    input  logic        ret_done_i,
    input  logic [63:0] W_valM_i,
    input  logic        halt_commit_i,
    output logic [63:0] pc_o,
    output logic        f_valid_o,
    output logic [2:0]  stat_o,
    output logic        halted_o,
    output logic        ret_timeout_o
);

    localparam logic [3:0] IHALT = 4'd0;
    localparam logic [3:0] IJXX  = 4'd7;
    localparam logic [3:0] ICALL = 4'd8;
    localparam logic [3:0] IRET  = 4'd9;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_RET_WAIT  = 2'd1,
        ST_HALT_PEND = 2'd2,
        ST_HALTED    = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] pred_pc_q, pred_pc_d;
    logic [3:0]  ret_cnt_q, ret_cnt_d;
    logic        ret_to_q, ret_to_d;
    logic        accept;

    // Mispredict outranks ret_done: a ret seen alongside it is on the squashed path.
    always_comb begin
        if (mispredict_i) begin
            pc_o = M_valA_i;
        end else if (ret_done_i) begin
            pc_o = W_valM_i;
        end else begin
            pc_o = pred_pc_q;
        end
    end

    always_comb begin
        if (imem_error_i) begin
            stat_o = STAT_ADR;
        end else if (!instr_valid_i) begin
            stat_o = STAT_INS;
        end else if (icode_i == IHALT) begin
            stat_o = STAT_HLT;
        end else begin
            stat_o = STAT_AOK;
        end
    end

    always_comb begin
        case (state_q)
            ST_RUN:       f_valid_o = 1'b1;
            ST_RET_WAIT:  f_valid_o = ret_done_i | mispredict_i;
            ST_HALT_PEND: f_valid_o = mispredict_i;
            ST_HALTED:    f_valid_o = 1'b0;
            default:      f_valid_o = 1'b0;
        endcase
    end

    assign accept        = f_valid_o && (!stall_i || mispredict_i);
    assign halted_o      = (state_q == ST_HALTED);
    assign ret_timeout_o = ret_to_q;

    always_comb begin
        state_d   = state_q;
        pred_pc_d = pred_pc_q;
        ret_cnt_d = ret_cnt_q;
        ret_to_d  = ret_to_q;

        if (accept) begin
            pred_pc_d = ((icode_i == IJXX) || (icode_i == ICALL)) ? valC_i : valP_i;
            ret_cnt_d = 4'd0;
            if (stat_o != STAT_AOK) begin
                state_d = ST_HALT_PEND;
            end else if (icode_i == IRET) begin
                state_d = ST_RET_WAIT;
            end else begin
                state_d = ST_RUN;
            end
        end else if (state_q == ST_RET_WAIT) begin
            if (ret_cnt_q == RET_TIMEOUT) begin
                state_d  = ST_HALTED;
                ret_to_d = 1'b1;
            end else begin
                ret_cnt_d = ret_cnt_q + 4'd1;
            end
        end

        // A committed halt wins over any transition chosen above.
        if (halt_commit_i) begin
            state_d = ST_HALTED;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_RUN;
            pred_pc_q <= RESET_PC;
            ret_cnt_q <= 4'd0;
            ret_to_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pred_pc_q <= pred_pc_d;
            ret_cnt_q <= ret_cnt_d;
            ret_to_q  <= ret_to_d;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: expectations queued per step, popped and checked mid-cycle.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  icode = 4'd6;
    logic [63:0] valC = 64'h0;
    logic [63:0] valP = 64'h2;
    logic        instr_valid = 1'b1;
    logic        imem_error = 1'b0;
    logic        stall = 1'b0;
    logic        mispredict = 1'b0;
    logic [63:0] M_valA = 64'h0;
    logic        ret_done = 1'b0;
    logic [63:0] W_valM = 64'h0;
    logic        halt_commit = 1'b0;
    logic [63:0] pc;
    logic        f_valid;
    logic [2:0]  stat;
    logic        halted;
    logic        ret_timeout;

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    typedef struct {
        string       tag;
        bit          pc_care;
        logic [63:0] pc;
        logic        fv;
        logic [2:0]  st;
        logic        h;
        logic        to;
    } exp_t;

    exp_t sb[$];

    pc_sequencer #(.RESET_PC(64'h0), .RET_TIMEOUT(4'd15)) dut (
        .clk_i(clk), .rst_i(rst),
        .icode_i(icode), .valC_i(valC), .valP_i(valP),
        .instr_valid_i(instr_valid), .imem_error_i(imem_error),
        .stall_i(stall), .mispredict_i(mispredict), .M_valA_i(M_valA),
        .ret_done_i(ret_done), .W_valM_i(W_valM), .halt_commit_i(halt_commit),
        .pc_o(pc), .f_valid_o(f_valid), .stat_o(stat),
        .halted_o(halted), .ret_timeout_o(ret_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag, input bit pc_care, input logic [63:0] epc,
                            input logic fv, input logic [2:0] st, input logic h, input logic to);
        exp_t e;
        e.tag = tag; e.pc_care = pc_care; e.pc = epc;
        e.fv = fv; e.st = st; e.h = h; e.to = to;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            fails++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = sb.pop_front();
            if (e.pc_care) chk({e.tag, ".pc"}, pc, e.pc);
            chk({e.tag, ".f_valid"}, {63'd0, f_valid}, {63'd0, e.fv});
            chk({e.tag, ".stat"}, {61'd0, stat}, {61'd0, e.st});
            chk({e.tag, ".halted"}, {63'd0, halted}, {63'd0, e.h});
            chk({e.tag, ".ret_timeout"}, {63'd0, ret_timeout}, {63'd0, e.to});
        end
    endtask

    // Inputs are driven 1 time unit after a rising edge; outputs sampled 2 units later.
    task automatic step(input string tag, input bit pc_care, input logic [63:0] epc,
                        input logic fv, input logic [2:0] st, input logic h, input logic to);
        push_exp(tag, pc_care, epc, fv, st, h, to);
        #2;
        check_out();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_overrides();
        stall = 1'b0; mispredict = 1'b0; ret_done = 1'b0; halt_commit = 1'b0;
        imem_error = 1'b0; instr_valid = 1'b1; icode = 4'd6;
    endtask

    initial begin
        #1 rst = 1'b1;
        step("reset", 1, 64'h0, 1, 3'd1, 0, 0);
        rst = 1'b0;

        for (int k = 0; k < 8; k++) begin
            valP = 64'(2 * k + 2);
            step($sformatf("seq%0d", k), 1, 64'(2 * k), 1, 3'd1, 0, 0);
        end

        icode = 4'd7; valC = 64'h80; valP = 64'h19;
        step("jxx", 1, 64'h10, 1, 3'd1, 0, 0);
        icode = 4'd6; valP = 64'h82;
        step("pred", 1, 64'h80, 1, 3'd1, 0, 0);
        mispredict = 1'b1; stall = 1'b1; M_valA = 64'h19; valP = 64'h1b;
        step("mispredict", 1, 64'h19, 1, 3'd1, 0, 0);
        clear_overrides(); valP = 64'h20;
        step("recover", 1, 64'h1b, 1, 3'd1, 0, 0);

        stall = 1'b1; valP = 64'h22;
        step("stall0", 1, 64'h20, 1, 3'd1, 0, 0);
        step("stall1", 1, 64'h20, 1, 3'd1, 0, 0);
        stall = 1'b0;
        step("release", 1, 64'h20, 1, 3'd1, 0, 0);

        icode = 4'd9; valP = 64'h23;
        step("ret", 1, 64'h22, 1, 3'd1, 0, 0);
        icode = 4'd6; valP = 64'h24;
        for (int i = 1; i <= 3; i++) step($sformatf("ret_bubble%0d", i), 1, 64'h23, 0, 3'd1, 0, 0);
        ret_done = 1'b1; W_valM = 64'h40; valP = 64'h42;
        step("ret_done", 1, 64'h40, 1, 3'd1, 0, 0);
        ret_done = 1'b0; valP = 64'h44;
        step("ret_run", 1, 64'h42, 1, 3'd1, 0, 0);

        ret_done = 1'b1; W_valM = 64'h99; mispredict = 1'b1; M_valA = 64'h50; valP = 64'h52;
        step("mp_over_ret", 1, 64'h50, 1, 3'd1, 0, 0);
        clear_overrides();

        imem_error = 1'b1; instr_valid = 1'b0; valP = 64'h54;
        step("adr", 1, 64'h52, 1, 3'd3, 0, 0);
        imem_error = 1'b0;
        step("ins_pend", 1, 64'h54, 0, 3'd4, 0, 0);
        instr_valid = 1'b1; mispredict = 1'b1; M_valA = 64'h60; valP = 64'h62;
        step("squash_pend", 1, 64'h60, 1, 3'd1, 0, 0);
        clear_overrides();

        icode = 4'd0; valP = 64'h63;
        step("hlt", 1, 64'h62, 1, 3'd2, 0, 0);
        icode = 4'd6; valP = 64'h65;
        step("halt_pend", 1, 64'h63, 0, 3'd1, 0, 0);
        halt_commit = 1'b1; mispredict = 1'b1; M_valA = 64'h70; valP = 64'h72;
        step("hc_with_mp", 1, 64'h70, 1, 3'd1, 0, 0);
        clear_overrides();
        for (int i = 0; i < 10; i++) step($sformatf("halted%0d", i), 0, 64'h0, 0, 3'd1, 1, 0);

        rst = 1'b1;
        step("reset2", 1, 64'h0, 1, 3'd1, 0, 0);
        rst = 1'b0;

        icode = 4'd9; valP = 64'h1;
        step("ret2", 1, 64'h0, 1, 3'd1, 0, 0);
        icode = 4'd6; valP = 64'h3;
        for (int i = 1; i <= 16; i++) step($sformatf("ret_wait%0d", i), 1, 64'h1, 0, 3'd1, 0, 0);
        step("timeout", 1, 64'h1, 0, 3'd1, 1, 1);
        step("timeout_sticky", 1, 64'h1, 0, 3'd1, 1, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

- Sequential front-end controller for the Y86-64 pipeline.
- Owns the predicted-PC register and drives the PC into the combinational fetch block.
- Chooses the next fetch address from three sources: prediction, branch-misprediction recovery, and `ret` return address.
- Sequences `ret` bubbles, freezes fetch on halt or fetch faults, and reports the fetch status of each instruction.

## Interface

**Parameters**
- `RESET_PC`, default 64'h0: PC fetched after reset.
- `RET_TIMEOUT`, default 4'd15: maximum number of RET_WAIT cycles before a fatal timeout.

**Ports**
- `clk_i` in 1: single clock, rising edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `icode_i` in 4: icode of the instruction at `pc_o`, from fetch.
- `valC_i` in 64: constant word of the instruction at `pc_o`, from fetch.
- `valP_i` in 64: fall-through PC of the instruction at `pc_o`, from fetch.
- `instr_valid_i` in 1: fetch instruction-valid flag.
- `imem_error_i` in 1: fetch address-error flag.
- `stall_i` in 1: hold the fetch stage (load/use hazard).
- `mispredict_i` in 1: the jump in the memory stage was mispredicted.
- `M_valA_i` in 64: correct fall-through PC for a misprediction.
- `ret_done_i` in 1: a `ret` is in write-back this cycle.
- `W_valM_i` in 64: return address carried by that `ret`.
- `halt_commit_i` in 1: a non-AOK status reached write-back.
- `pc_o` out 64: fetch address, goes to fetch `PC_i`.
- `f_valid_o` out 1: the instruction at `pc_o` is real and enters decode. Otherwise decode loads a bubble.
- `stat_o` out 3: fetch status of the instruction at `pc_o`.
  - 1 = AOK, 2 = HLT, 3 = ADR, 4 = INS.
- `halted_o` out 1: core has halted. Sticky until reset.
- `ret_timeout_o` out 1: RET_WAIT exceeded `RET_TIMEOUT`. Sticky until reset.

## Operation

**PC selection (combinational)**
- `pc_o` is chosen in this priority order:
  - `mispredict_i` → `M_valA_i`
  - `ret_done_i` → `W_valM_i`
  - otherwise → `pred_pc`.

**Fetch status (combinational)**
- `stat_o` is chosen in this priority order:
  - `imem_error_i` → 3
  - `!instr_valid_i` → 4
  - `icode_i == IHALT` (0) → 2
  - otherwise → 1.

**States**
- Encoding: RUN = 0, RET_WAIT = 1, HALT_PEND = 2, HALTED = 3.

**`f_valid_o`**
- 1 in RUN.
- 1 in RET_WAIT only when `ret_done_i`.
- 1 in RET_WAIT or HALT_PEND when `mispredict_i`.
- 0 in HALTED.

**Accept**
- Accept = `f_valid_o && (!stall_i || mispredict_i)`. Misprediction overrides stall.
- On accept, `pred_pc` loads `valC_i` when `icode_i` is IJXX (7) or ICALL (8); otherwise it loads `valP_i`.
- On accept, the next state is decided by the accepted instruction:
  - `stat_o != 1` → HALT_PEND.
  - `icode_i == IRET` (9) → RET_WAIT.
  - otherwise → RUN.
- No accept → `pred_pc` and state hold. The exceptions are the timeout and halt transitions below.

**`ret_cnt` (4 bits)**
- Cleared on every accept.
- Increments each RET_WAIT cycle that has no accept.
- If `ret_cnt == RET_TIMEOUT` while in RET_WAIT → HALTED and `ret_timeout_o` sets.

**`halt_commit_i`**
- Forces HALTED from any state. It has priority over every other transition in that cycle.
- HALTED is left only by reset.

**Squash recovery**
- In RET_WAIT or HALT_PEND, `mispredict_i` means the `ret`, halt or fault was on the wrong path.
- The instruction at `M_valA_i` is accepted, and the state is re-derived from it.

**`halted_o`**
- `halted_o` = (state == HALTED).

## Timing

**Reset values** (asynchronous on `rst_i` high)
- `pred_pc` = `RESET_PC`, state = RUN, `ret_cnt` = 0, `ret_timeout_o` = 0.
- With no override inputs, `pc_o` = `RESET_PC`.
- `f_valid_o` = 1 and `halted_o` = 0 while in reset.
- Reset asserted mid-RET_WAIT or in HALTED returns to RUN at `RESET_PC` on the same edge.

**Latency**
- Redirects take effect in the same cycle: zero-cycle `pc_o` response to `mispredict_i` and `ret_done_i`.
- State and `pred_pc` update on the next rising edge.

**`ret` sequencing**
- A `ret` accepted in cycle t gives `f_valid_o` = 0 in cycles t+1…t+3.
- With the standard pipeline, `ret_done_i` arrives in t+4 and fetch resumes from `W_valM_i`.

**Stall**
- `pc_o` and `f_valid_o` are stable.
- No state or `pred_pc` change, and `ret_cnt` does not count RUN cycles.

**Simultaneous events**
- `mispredict_i` and `ret_done_i` together → `M_valA_i` wins. The `ret` is in a squashed path.
- `halt_commit_i` together with `mispredict_i` → HALTED.

**Arithmetic**
- PC values are 64-bit, passed through with no wrap checks. Address faults come from `imem_error_i`.

## Test plan

- **Reset / sequential fetch:** reset, then `icode_i`=6 with `valP_i`=`pc_o`+2 each cycle → `pc_o` 0, 2, 4 …; `f_valid_o`=1; `stat_o`=1.
- **Jump prediction then recovery:** jxx at 0x10 with `valC_i`=0x80 → next `pc_o`=0x80. Two cycles later `mispredict_i`=1 with `M_valA_i`=0x19 → same-cycle `pc_o`=0x19; `pred_pc` then takes that instruction's `valP_i`.
- **`ret`:** `ret` accepted at cycle t → `f_valid_o`=0 in t+1…t+3. `ret_done_i`=1 with `W_valM_i`=0x40 at t+4 → `pc_o`=0x40, `f_valid_o`=1, state RUN.
- **Stall during RUN:** `stall_i`=1 for 2 cycles at `pc_o`=0x20 → `pc_o` holds 0x20 and the state does not change; it advances on the cycle after release.
- **Halt:**
  - `icode_i`=0 → `stat_o`=2, HALT_PEND, `f_valid_o`=0.
  - A later `mispredict_i` → RUN.
  - Otherwise `halt_commit_i` → `halted_o`=1, held for 10 cycles until `rst_i`.
- **Faults/timeout:**
  - `imem_error_i`=1 → `stat_o`=3.
  - `instr_valid_i`=0 → `stat_o`=4.
  - `ret` with no `ret_done_i` for 16 cycles → `ret_timeout_o`=1, `halted_o`=1.
